// File: rtl/spi_upcount_pkg.sv
// Shared constants and types for the SPI up-counter link.
// Used by the master side, this receiver and its bench.
package spi_upcount_pkg;

  localparam int FRAME_BITS = 16;
  localparam int MAX_COUNT  = 9999;

  typedef enum logic [1:0] {
    IDLE,
    RX_HI,
    RX_LO,
    CHECK
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchroniser chain with rise/fall pulse detection.
// Edges are suppressed until the line is seen at its idle level.
module spi_sync_edge #(
  parameter int   STAGES   = 2,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  localparam logic [1:0] WARM_MAX = 2'(STAGES);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic [1:0]        warm_q, warm_d;
  logic              armed_q, armed_d;
  logic              level;
  logic              warm_done;

  assign level     = sync_q[STAGES-1];
  assign warm_done = (warm_q == WARM_MAX);

  // Shift the chain, remember the last level, arm once flushed and idle.
  always_comb begin
    sync_d  = {sync_q[STAGES-2:0], d};
    prev_d  = level;
    warm_d  = warm_done ? warm_q : warm_q + 2'd1;
    armed_d = armed_q | (warm_done & (level == IDLE_VAL));
  end

  // Chain, edge history and arming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= {STAGES{IDLE_VAL}};
      prev_q  <= IDLE_VAL;
      warm_q  <= 2'd0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      warm_q  <= warm_d;
      armed_q <= armed_d;
    end
  end

  assign rise = armed_q & level & ~prev_q;
  assign fall = armed_q & ~level & prev_q;

endmodule

// File: rtl/spi_upcount_slave_rx.sv
// SPI mode-0 slave receiving 16-bit counter frames.
// Accepted values strobe o_valid; the last one is read back on miso.
module spi_upcount_slave_rx
  import spi_upcount_pkg::*;
#(
  parameter int DATA_W      = 14,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss,
  output logic              miso,
  output logic [DATA_W-1:0] o_counter,
  output logic              o_valid,
  output logic              o_frame_err
);

  localparam int PAD_W = FRAME_BITS - DATA_W;

  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_i;

  logic sclk_rise, sclk_fall;
  logic ss_rise, ss_fall;

  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   mosi_s;

  state_e state_q, state_d;

  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [FRAME_BITS-1:0] rb_q, rb_d;
  logic                  ovr_q, ovr_d;
  logic [DATA_W-1:0]     counter_q, counter_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;

  // Reset asserts at once and releases on a clock edge.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b0};
  end

  // Reset release synchroniser.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_sync_q <= 2'b11;
    else       rst_sync_q <= rst_sync_d;
  end

  assign rst_i = rst_sync_q[1];

  spi_sync_edge #(
    .STAGES   (SYNC_STAGES),
    .IDLE_VAL (1'b0)
  ) u_sclk_sync (
    .clk  (clk),
    .rst  (rst_i),
    .d    (sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(
    .STAGES   (SYNC_STAGES),
    .IDLE_VAL (1'b1)
  ) u_ss_sync (
    .clk  (clk),
    .rst  (rst_i),
    .d    (ss),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  // mosi only needs the same delay as sclk, no edge detect.
  always_comb begin
    if (SYNC_STAGES > 1)
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    else
      mosi_sync_d = {SYNC_STAGES{mosi}};
  end

  // mosi synchroniser chain.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) mosi_sync_q <= '0;
    else       mosi_sync_q <= mosi_sync_d;
  end

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // FSM state register.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; ss edges win over sclk edges.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (ss_fall) state_d = RX_HI;
      end
      RX_HI: begin
        if (ss_rise)
          state_d = IDLE;
        else if (sclk_rise && bit_cnt_q == 4'd7)
          state_d = RX_LO;
      end
      RX_LO: begin
        if (ss_rise)
          state_d = IDLE;
        else if (sclk_rise && bit_cnt_q == 4'd15)
          state_d = CHECK;
      end
      CHECK: begin
        if (ss_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: shifting, readback, frame accept or reject.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rb_d      = rb_q;
    ovr_d     = ovr_q;
    counter_d = counter_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ss_fall) begin
          bit_cnt_d = 4'd0;
          shift_d   = '0;
          ovr_d     = 1'b0;
          rb_d      = {{PAD_W{1'b0}}, counter_q};
        end
      end
      RX_HI, RX_LO: begin
        if (ss_rise) begin
          err_d = 1'b1;
          rb_d  = '0;
        end else begin
          if (sclk_rise) begin
            shift_d   = {shift_q[FRAME_BITS-2:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
          if (sclk_fall)
            rb_d = {rb_q[FRAME_BITS-2:0], 1'b0};
        end
      end
      CHECK: begin
        if (ss_rise) begin
          rb_d = '0;
          if (!ovr_q && shift_q[FRAME_BITS-1:DATA_W] == '0) begin
            counter_d = shift_q[DATA_W-1:0];
            valid_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          if (sclk_rise) ovr_d = 1'b1;
          if (sclk_fall)
            rb_d = {rb_q[FRAME_BITS-2:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt_q <= 4'd0;
      shift_q   <= '0;
      rb_q      <= '0;
      ovr_q     <= 1'b0;
      counter_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rb_q      <= rb_d;
      ovr_q     <= ovr_d;
      counter_q <= counter_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign miso        = rb_q[FRAME_BITS-1];
  assign o_counter   = counter_q;
  assign o_valid     = valid_q;
  assign o_frame_err = err_q;

endmodule

// File: tb/tb_spi_upcount_slave_rx.sv
// Bench for spi_upcount_slave_rx: directed and random frames
// checked against a frame-level model of the receiver.
module tb_spi_upcount_slave_rx;
  import spi_upcount_pkg::*;

  localparam int DW = 14;
  localparam int H  = 5;

  logic clk = 1'b0;
  logic reset, sclk, mosi, ss;
  logic miso2, valid2, err2;
  logic miso3, valid3, err3;
  logic [DW-1:0] cnt2, cnt3;

  always #5 clk = ~clk;

  spi_upcount_slave_rx #(.DATA_W(DW), .SYNC_STAGES(2)) u_dut2 (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .ss(ss),
    .miso(miso2), .o_counter(cnt2), .o_valid(valid2),
    .o_frame_err(err2)
  );

  spi_upcount_slave_rx #(.DATA_W(DW), .SYNC_STAGES(3)) u_dut3 (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .ss(ss),
    .miso(miso3), .o_counter(cnt3), .o_valid(valid3),
    .o_frame_err(err3)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int v2_n = 0, e2_n = 0, v3_n = 0, e3_n = 0;

  logic [DW-1:0] exp_cnt;
  logic [15:0]   rb_word;

  always @(negedge clk) begin
    if (valid2) v2_n++;
    if (err2)   e2_n++;
    if (valid3) v3_n++;
    if (err3)   e3_n++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  function automatic bit accepted(input logic [31:0] data,
                                  input int nbits);
    return (nbits == 16) && (data[15:14] == 2'b00);
  endfunction

  task automatic send_bits(input logic [31:0] data, input int nbits,
                           input bit raise);
    rb_word = '0;
    ss = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = data[i];
      repeat (H) @(negedge clk);
      sclk = 1'b1;
      if (nbits - 1 - i < 16) rb_word = {rb_word[14:0], miso2};
      repeat (H) @(negedge clk);
      sclk = 1'b0;
    end
    mosi = 1'b0;
    repeat (H) @(negedge clk);
    if (raise) ss = 1'b1;
  endtask

  task automatic frame(input logic [31:0] data, input int nbits);
    send_bits(data, nbits, 1'b1);
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset;
    tests_run++;
    if (cnt2 !== '0) begin
      tests_failed++;
      $display("FAIL reset_cnt got %h want 0", cnt2);
    end
    tests_run++;
    if (valid2 !== 1'b0 || err2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_pulses got v=%b e=%b want 0 0", valid2, err2);
    end
    tests_run++;
    if (miso2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_miso got %b want 0", miso2);
    end
    tests_run++;
    if (u_dut2.state_q !== IDLE) begin
      tests_failed++;
      $display("FAIL reset_state got %0d want IDLE", u_dut2.state_q);
    end
  endtask

  task automatic test_single;
    int v0, e0;
    v0 = v2_n; e0 = e2_n;
    frame(32'h0005, 16);
    exp_cnt = 14'd5;
    tests_run++;
    if (v2_n - v0 !== 1 || e2_n - e0 !== 0) begin
      tests_failed++;
      $display("FAIL single_pulses got v=%0d e=%0d want 1 0",
               v2_n - v0, e2_n - e0);
    end
    tests_run++;
    if (cnt2 !== exp_cnt) begin
      tests_failed++;
      $display("FAIL single_cnt got %h want %h", cnt2, exp_cnt);
    end
    tests_run++;
    if (rb_word !== 16'h0000) begin
      tests_failed++;
      $display("FAIL single_miso got %h want 0000", rb_word);
    end
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = v2_n;
    frame(32'(MAX_COUNT), 16);
    tests_run++;
    if (cnt2 !== 14'(MAX_COUNT) || v2_n - v0 !== 1) begin
      tests_failed++;
      $display("FAIL b2b_first got %0d v=%0d want %0d v=1",
               cnt2, v2_n - v0, MAX_COUNT);
    end
    frame(32'h0001, 16);
    exp_cnt = 14'd1;
    tests_run++;
    if (cnt2 !== exp_cnt || v2_n - v0 !== 2) begin
      tests_failed++;
      $display("FAIL b2b_second got %0d v=%0d want 1 v=2",
               cnt2, v2_n - v0);
    end
    tests_run++;
    if (rb_word !== 16'h270F) begin
      tests_failed++;
      $display("FAIL b2b_miso got %h want 270f", rb_word);
    end
  endtask

  task automatic test_short;
    int v0, e0;
    v0 = v2_n; e0 = e2_n;
    frame(32'h0246, 11);
    tests_run++;
    if (e2_n - e0 !== 1 || v2_n - v0 !== 0) begin
      tests_failed++;
      $display("FAIL short_pulses got v=%0d e=%0d want 0 1",
               v2_n - v0, e2_n - e0);
    end
    tests_run++;
    if (cnt2 !== exp_cnt) begin
      tests_failed++;
      $display("FAIL short_cnt got %h want %h", cnt2, exp_cnt);
    end
    tests_run++;
    if (u_dut2.state_q !== IDLE) begin
      tests_failed++;
      $display("FAIL short_state got %0d want IDLE", u_dut2.state_q);
    end
  endtask

  task automatic test_long;
    int v0, e0;
    v0 = v2_n; e0 = e2_n;
    frame(32'h0000B, 17);
    tests_run++;
    if (e2_n - e0 !== 1 || v2_n - v0 !== 0 || cnt2 !== exp_cnt) begin
      tests_failed++;
      $display("FAIL long17 got v=%0d e=%0d cnt=%h want 0 1 %h",
               v2_n - v0, e2_n - e0, cnt2, exp_cnt);
    end
    frame(32'hC005, 16);
    tests_run++;
    if (e2_n - e0 !== 2 || v2_n - v0 !== 0 || cnt2 !== exp_cnt) begin
      tests_failed++;
      $display("FAIL pad_bits got v=%0d e=%0d cnt=%h want 0 2 %h",
               v2_n - v0, e2_n - e0, cnt2, exp_cnt);
    end
  endtask

  task automatic test_reset_mid;
    int v0, e0;
    send_bits(32'h1234 >> 7, 9, 1'b0);
    e0 = e2_n;
    reset = 1'b1;
    #1;
    tests_run++;
    if (cnt2 !== '0 || miso2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_out got cnt=%h miso=%b want 0 0",
               cnt2, miso2);
    end
    tests_run++;
    if (u_dut2.state_q !== IDLE) begin
      tests_failed++;
      $display("FAIL midreset_state got %0d want IDLE", u_dut2.state_q);
    end
    ss = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    tests_run++;
    if (e2_n - e0 !== 0) begin
      tests_failed++;
      $display("FAIL midreset_err got %0d want 0", e2_n - e0);
    end
    exp_cnt = '0;
    v0 = v2_n;
    frame(32'h0042, 16);
    exp_cnt = 14'h42;
    tests_run++;
    if (cnt2 !== exp_cnt || v2_n - v0 !== 1) begin
      tests_failed++;
      $display("FAIL midreset_next got %h v=%0d want 42 v=1",
               cnt2, v2_n - v0);
    end
    tests_run++;
    if (rb_word !== 16'h0000) begin
      tests_failed++;
      $display("FAIL midreset_miso got %h want 0000", rb_word);
    end
  endtask

  task automatic test_latency;
    int lat2, lat3;
    logic [DW-1:0] v;
    v = 14'($urandom_range(0, 16383));
    lat2 = 0; lat3 = 0;
    send_bits(32'(v), 16, 1'b0);
    ss = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      #1;
      if (valid2 && lat2 == 0) lat2 = n;
      if (valid3 && lat3 == 0) lat3 = n;
    end
    repeat (4) @(negedge clk);
    exp_cnt = v;
    tests_run++;
    if (lat2 !== 2 + 1) begin
      tests_failed++;
      $display("FAIL latency_s2 got %0d want 3", lat2);
    end
    tests_run++;
    if (lat3 !== 3 + 1) begin
      tests_failed++;
      $display("FAIL latency_s3 got %0d want 4", lat3);
    end
    tests_run++;
    if (cnt3 !== v || cnt2 !== v) begin
      tests_failed++;
      $display("FAIL latency_cnt got %h/%h want %h", cnt2, cnt3, v);
    end
  endtask

  task automatic test_random;
    int v0, e0, kind, nbits;
    logic [31:0] data;
    logic [DW-1:0] pre;
    bit ok;
    for (int it = 0; it < 12; it++) begin
      kind = $urandom_range(0, 3);
      data = $urandom();
      nbits = 16;
      case (kind)
        0: data = 32'($urandom_range(0, 16383));
        1: data = 32'($urandom_range(0, 16383))
                  | (32'($urandom_range(1, 3)) << 14);
        2: nbits = $urandom_range(1, 15);
        default: nbits = $urandom_range(17, 20);
      endcase
      pre = exp_cnt;
      v0 = v2_n; e0 = e2_n;
      frame(data, nbits);
      ok = accepted(data, nbits);
      if (ok) exp_cnt = data[DW-1:0];
      tests_run++;
      if (cnt2 !== exp_cnt) begin
        tests_failed++;
        $display("FAIL rand%0d_cnt got %h want %h", it, cnt2, exp_cnt);
      end
      tests_run++;
      if (v2_n - v0 !== int'(ok) || e2_n - e0 !== int'(!ok)) begin
        tests_failed++;
        $display("FAIL rand%0d_pulses got v=%0d e=%0d want %0d %0d",
                 it, v2_n - v0, e2_n - e0, int'(ok), int'(!ok));
      end
      if (nbits >= 16) begin
        tests_run++;
        if (rb_word !== {2'b00, pre}) begin
          tests_failed++;
          $display("FAIL rand%0d_miso got %h want %h",
                   it, rb_word, {2'b00, pre});
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    ss = 1'b1;
    exp_cnt = '0;
    rb_word = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_short();
    test_long();
    test_reset_mid();
    test_latency();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
